// File: rtl/ofdm_codec_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : ofdm_codec_pkg                                                |
// | Purpose    : Shared types, widths and helpers for the OFDM codec blocks.   |
// |              Holds the decoder-scheduler state encoding, the codeword and  |
// |              nibble widths, and the rotate-priority selection function     |
// |              used by round-robin arbiters (up to 8 requesters).            |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
package ofdm_codec_pkg;

    localparam int CW_W  = 8;   // Hamming codeword width
    localparam int NIB_W = 4;   // decoded data width

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } dec_state_t;

    // Rotate-priority selection: returns the first index with req set,
    // searching strictly after 'last' and wrapping modulo 'n' (n <= 8).
    // With no requester the pointer value is returned unchanged; callers
    // qualify the result with their own any-request flag.
    // The search runs from the farthest candidate towards the nearest so the
    // nearest hit is the one left standing.
    function automatic int unsigned rr_select(input logic [7:0]  req,
                                              input int unsigned last,
                                              input int unsigned n);
        int unsigned idx;
        rr_select = last;
        for (int unsigned k = 8; k >= 1; k--) begin
            if (k <= n) begin
                idx = last + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (req[idx[2:0]]) begin
                    rr_select = idx;
                end
            end
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : rr_picker                                                     |
// | Purpose    : Combinational round-robin winner selection. Given the request |
// |              vector and the most recently granted index, returns the first |
// |              requester strictly after it (wrapping).                       |
// | Ports      : req        in  NCH       request vector                       |
// |              last_grant in  clog2(NCH) previously granted channel          |
// |              any        out 1         at least one request present         |
// |              winner     out clog2(NCH) selected channel (valid with any)   |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module rr_picker
    import ofdm_codec_pkg::*;
#(
    parameter int NCH = 4
) (
    input  logic [NCH-1:0]         req,
    input  logic [$clog2(NCH)-1:0] last_grant,
    output logic                   any,
    output logic [$clog2(NCH)-1:0] winner
);

    localparam int CHW = $clog2(NCH);

    assign any    = |req;
    assign winner = CHW'(rr_select(8'(req), 32'(last_grant), NCH));

endmodule
`default_nettype wire

// File: rtl/hamming_dec_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : hamming_dec_arbiter                                           |
// | Purpose    : Shares one serial Hamming decoder among NCH channels. Grants  |
// |              one channel at a time round-robin, shifts its 8-bit codeword  |
// |              into the decoder LSB first, waits DEC_LAT cycles, captures    |
// |              the nibble and holds it under a valid/ready handshake.        |
// | Ports      : clk        in  1          rising-edge clock                   |
// |              reset      in  1          async active-high reset             |
// |              req        in  NCH        per-channel request                 |
// |              cw         in  NCH*8      per-channel codewords               |
// |              ack        out NCH        one-hot grant pulse                 |
// |              dec_en     out 1          decoder shift enable                |
// |              dec_in     out 1          decoder serial data, LSB first      |
// |              dec_out    in  4          decoder result                      |
// |              out_valid  out 1          result available                    |
// |              out_ready  in  1          downstream accept                   |
// |              out_data   out 4          decoded nibble                      |
// |              out_ch     out clog2(NCH) source channel of out_data          |
// |              busy       out 1          not idle                            |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module hamming_dec_arbiter
    import ofdm_codec_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int DEC_LAT = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NCH-1:0]         req,
    input  logic [NCH*CW_W-1:0]    cw,
    output logic [NCH-1:0]         ack,
    output logic                   dec_en,
    output logic                   dec_in,
    input  logic [NIB_W-1:0]       dec_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NIB_W-1:0]       out_data,
    output logic [$clog2(NCH)-1:0] out_ch,
    output logic                   busy
);

    localparam int CHW = $clog2(NCH);

    dec_state_t       r_state;
    dec_state_t       w_next_state;
    logic [CW_W-1:0]  r_cw;
    logic [CHW-1:0]   r_ch;
    logic [CHW-1:0]   r_last;
    logic [2:0]       r_bit_cnt;
    logic [3:0]       r_wait_cnt;

    logic             w_any;
    logic [CHW-1:0]   w_winner;
    logic [CW_W-1:0]  w_sel_cw;
    logic             w_grant;
    logic             w_capture;
    logic             w_accept;

    rr_picker #(
        .NCH (NCH)
    ) u_rr_picker (
        .req        (req),
        .last_grant (r_last),
        .any        (w_any),
        .winner     (w_winner)
    );

    // Codeword of the current winner
    always_comb begin
        w_sel_cw = '0;
        for (int c = 0; c < NCH; c++) begin
            if (w_winner == CHW'(c)) begin
                w_sel_cw = cw[c*CW_W +: CW_W];
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and control strobes
    always_comb begin
        w_next_state = r_state;
        w_grant      = 1'b0;
        w_capture    = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_grant      = 1'b1;
                    w_next_state = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_bit_cnt == 3'd7) begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_wait_cnt == 4'd0) begin
                    w_capture    = 1'b1;
                    w_next_state = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_valid && out_ready) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Decoder drive is decoded straight from state so that an asynchronous
    // reset drops dec_en in the same instant the state register clears.
    assign dec_en = (r_state == ST_SHIFT);
    assign dec_in = dec_en & r_cw[r_bit_cnt];
    assign busy   = (r_state != ST_IDLE);

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack        <= '0;
            r_cw       <= '0;
            r_ch       <= '0;
            r_last     <= CHW'(NCH - 1);
            r_bit_cnt  <= '0;
            r_wait_cnt <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ch     <= '0;
        end else begin
            ack <= '0;
            if (w_grant) begin
                ack       <= NCH'(1) << w_winner;
                r_cw      <= w_sel_cw;
                r_ch      <= w_winner;
                r_last    <= w_winner;
                r_bit_cnt <= 3'd0;
            end
            if (r_state == ST_SHIFT) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    r_wait_cnt <= 4'(DEC_LAT - 1);
                end
            end
            if (r_state == ST_WAIT) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end
            if (w_capture) begin
                out_data  <= dec_out;
                out_ch    <= r_ch;
                out_valid <= 1'b1;
            end
            if (w_accept) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hamming_dec_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_hamming_dec_arbiter                                        |
// | Purpose    : Self-checking bench for hamming_dec_arbiter with a behavioural|
// |              serial Hamming(8,4) decoder and a transaction-level model of  |
// |              round-robin grant order, bit order, latency and handshakes.   |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module tb_hamming_dec_arbiter;

    localparam int NCH     = 4;
    localparam int DEC_LAT = 2;
    localparam int CHW     = $clog2(NCH);

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NCH-1:0]       req;
    logic [NCH*8-1:0]     cw;
    logic [NCH-1:0]       ack;
    logic                 dec_en;
    logic                 dec_in;
    logic [3:0]           dec_out;
    logic                 out_valid;
    logic                 out_ready;
    logic [3:0]           out_data;
    logic [CHW-1:0]       out_ch;
    logic                 busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int model_last;
    int pend [NCH];
    bit rnd_en;
    int ack_cyc;

    always #5 clk = ~clk;

    hamming_dec_arbiter #(
        .NCH     (NCH),
        .DEC_LAT (DEC_LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .cw        (cw),
        .ack       (ack),
        .dec_en    (dec_en),
        .dec_in    (dec_in),
        .dec_out   (dec_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .busy      (busy)
    );

    // Hamming(7,4) with positions 1..7 at cw[0..6]; cw[7] is overall parity.
    function automatic logic [3:0] ham_dec(input logic [7:0] c);
        logic [7:0] v;
        int s;
        v = c;
        s = 0;
        for (int p = 1; p <= 7; p++) begin
            if (v[p-1]) s = s ^ p;
        end
        if (s != 0) v[s-1] = ~v[s-1];
        return {v[6], v[5], v[4], v[2]};
    endfunction

    // Serial decoder model: result becomes valid DEC_LAT cycles after the last
    // shifted bit; before that it shows the complement so early sampling shows.
    logic [7:0] dm_sh;
    int         dm_cnt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dm_sh  <= '0;
            dm_cnt <= 0;
        end else if (dec_en) begin
            dm_sh  <= {dec_in, dm_sh[7:1]};
            dm_cnt <= 0;
        end else if (dm_cnt < 15) begin
            dm_cnt <= dm_cnt + 1;
        end
    end
    assign dec_out = (dm_cnt >= DEC_LAT - 1) ? ham_dec(dm_sh) : ~ham_dec(dm_sh);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int model_pick(input logic [NCH-1:0] r, input int last);
        for (int k = 1; k <= NCH; k++) begin
            if (r[(last + k) % NCH]) return (last + k) % NCH;
        end
        return -1;
    endfunction

    task automatic rand_req();
        int c;
        if ($urandom_range(0, 5) == 0) begin
            c = $urandom_range(0, NCH - 1);
            if (!req[c]) begin
                pend[c]        = $urandom_range(1, 3);
                cw[c*8 +: 8]   = 8'($urandom);
                req[c]         = 1'b1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (rnd_en) rand_req();
    endtask

    // Winner either withdraws or presents its next word
    task automatic requester_update(input int w);
        pend[w]--;
        if (pend[w] > 0) cw[w*8 +: 8] = 8'($urandom);
        else             req[w] = 1'b0;
    endtask

    // Called in an IDLE cycle with req nonzero; returns in the IDLE cycle
    // following the accept edge.
    task automatic serve(input int hold_n);
        int         w;
        int         bad;
        logic [7:0] c;
        logic [7:0] obs;
        logic [3:0] exp_d;
        w         = model_pick(req, model_last);
        c         = cw[w*8 +: 8];
        exp_d     = ham_dec(c);
        out_ready = 1'b0;
        step();
        ack_cyc = cyc;
        check_eq("ack", 32'(ack), 32'(1) << w);
        model_last = w;
        requester_update(w);
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            obs[k] = dec_in;
            if (dec_en !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0) bad++;
            if (k > 0 && ack !== '0) bad++;
            step();
        end
        check_eq("dec_bits", obs, c);
        check_eq("shift_ctl", bad, 0);
        bad = 0;
        for (int k = 0; k < DEC_LAT; k++) begin
            if (dec_en !== 1'b0 || out_valid !== 1'b0 || ack !== '0 || busy !== 1'b1) bad++;
            step();
        end
        check_eq("wait_ctl", bad, 0);
        check_eq("out_valid", out_valid, 1);
        check_eq("out_data", out_data, exp_d);
        check_eq("out_ch", out_ch, w);
        bad = 0;
        for (int k = 0; k < hold_n; k++) begin
            if (out_valid !== 1'b1 || out_data !== exp_d || out_ch !== CHW'(w) ||
                ack !== '0 || dec_en !== 1'b0 || busy !== 1'b1) bad++;
            step();
        end
        if (hold_n > 0) begin
            if (out_valid !== 1'b1 || out_data !== exp_d || out_ch !== CHW'(w) || ack !== '0) bad++;
            check_eq("hold_frozen", bad, 0);
        end
        out_ready = 1'b1;
        step();
        check_eq("accept_idle", {out_valid, busy, dec_en, ack}, 0);
        out_ready = 1'b0;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int bad;
        int prev;
        int w;
        reset     = 1'b1;
        req       = '0;
        cw        = '0;
        out_ready = 1'b0;
        rnd_en    = 1'b0;
        for (int c = 0; c < NCH; c++) pend[c] = 0;
        model_last = NCH - 1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ctl", {ack, dec_en, dec_in, out_valid, busy}, 0);
        check_eq("rst_data", {out_data, out_ch}, 0);
        reset = 1'b0;
        step();

        // Quiet idle
        bad = 0;
        repeat (3) begin
            if (ack !== '0 || busy !== 1'b0 || dec_en !== 1'b0 || out_valid !== 1'b0) bad++;
            step();
        end
        check_eq("idle_quiet", bad, 0);

        // Single channel 0, known codeword
        req[0] = 1'b1; pend[0] = 1; cw[7:0] = 8'hA5;
        serve(0);

        // All channels requesting, back-to-back grants
        for (int c = 0; c < NCH; c++) begin
            req[c] = 1'b1; pend[c] = 1; cw[c*8 +: 8] = 8'($urandom);
        end
        pend[0] = 2;
        prev = 0;
        for (int i = 0; i < NCH + 1; i++) begin
            serve(0);
            if (i > 0) check_eq("grant_gap", ack_cyc - prev, 10 + DEC_LAT);
            prev = ack_cyc;
        end

        // Channel 2 last, then 0 and 2 together
        req[2] = 1'b1; pend[2] = 1; cw[23:16] = 8'($urandom);
        serve(0);
        req[0] = 1'b1; pend[0] = 1; cw[7:0]   = 8'($urandom);
        req[2] = 1'b1; pend[2] = 1; cw[23:16] = 8'($urandom);
        serve(1);
        serve(0);

        // Downstream stall
        req[1] = 1'b1; pend[1] = 1; cw[15:8] = 8'($urandom);
        serve(20);

        // Reset in the middle of shifting
        req[0] = 1'b1; pend[0] = 1; cw[7:0] = 8'($urandom);
        w = model_pick(req, model_last);
        step();
        check_eq("rst_test_ack", 32'(ack), 32'(1) << w);
        req = '0; pend[0] = 0;
        repeat (4) step();
        check_eq("rst_pre_en", dec_en, 1);
        reset = 1'b1;
        #1;
        check_eq("rst_async", {dec_en, dec_in, busy, ack, out_valid}, 0);
        step();
        step();
        reset = 1'b0;
        model_last = NCH - 1;
        req[0] = 1'b1; pend[0] = 1; cw[7:0]  = 8'($urandom);
        req[1] = 1'b1; pend[1] = 1; cw[15:8] = 8'($urandom);
        serve(0);
        serve(0);

        // Randomised traffic
        rnd_en = 1'b1;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            if (req != '0) begin
                serve($urandom_range(0, 3));
            end else begin
                step();
                if (ack !== '0 || busy !== 1'b0) bad++;
            end
        end
        check_eq("idle_noack", bad, 0);
        rnd_en = 1'b0;
        for (int i = 0; i < 4 * NCH && req != '0; i++) serve(0);
        check_eq("drained", 32'(req), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
